lfsr_rand_server: RTL

- Shares one internal B-bit pseudo-random generator among N requesters.
- Each granted request advances the generator STEPS times, then returns one word with a one-cycle acknowledge.
- Arbitration is round-robin, and the generator can be reseeded while idle.
- Sits between game/control logic and the shared random source.

---
 rtl/lfsr_rand_server.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/lfsr_rand_server.sv
// Round-robin server that shares one B-bit LFSR among N requesters.
// Each grant steps the LFSR STEPS times and returns the word with a one-cycle ack.
module lfsr_rand_server #(
  parameter int B     = 5,
  parameter int N     = 4,
  parameter int STEPS = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N-1:0]           req,
  input  logic                   seed_load,
  input  logic [B-1:0]           seed,
  output logic [N-1:0]           ack,
  output logic [$clog2(N)-1:0]   grant_idx,
  output logic [B-1:0]           rand_data,
  output logic                   busy
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ADVANCE = 2'd1,
    S_DELIVER = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [B-1:0]    gen_q, gen_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   grant_idx_q, grant_idx_d;
  logic [N-1:0]    ack_q, ack_d;
  logic [B-1:0]    rand_q, rand_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   pick_s;
  logic            found_s;
  int              idx_s;

  // One LFSR shift; an all-zero state is forced back to all-ones.
  function automatic logic [B-1:0] lfsr_step(input logic [B-1:0] v);
    logic [B-1:0] r;
    if (v == '0) begin
      r = {B{1'b1}};
    end else begin
      r = {v[0] ^ v[2], v[B-1:1]};
    end
    return r;
  endfunction

  // Round-robin pick: first set request at or above the rr pointer, wrapping.
  always_comb begin
    pick_s  = rr_q;
    found_s = 1'b0;
    idx_s   = 0;
    for (int i = 0; i < N; i++) begin
      idx_s = (int'(rr_q) + i) % N;
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        pick_s  = IW'(idx_s);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    gen_d       = gen_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    grant_idx_d = grant_idx_q;
    ack_d       = '0;
    rand_d      = rand_q;
    case (state_q)
      S_IDLE: begin
        if (seed_load) begin
          gen_d = (seed == '0) ? {B{1'b1}} : seed;
        end else if (req != '0) begin
          grant_idx_d = pick_s;
          cnt_d       = '0;
          state_d     = S_ADVANCE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADVANCE: begin
        gen_d = lfsr_step(gen_q);
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(STEPS - 1)) begin
          rand_d  = gen_d;
          ack_d   = {{(N-1){1'b0}}, 1'b1} << grant_idx_q;
          state_d = S_DELIVER;
          if (int'(grant_idx_q) == N - 1) begin
            rr_d = '0;
          end else begin
            rr_d = grant_idx_q + 1'b1;
          end
        end else begin
          state_d = S_ADVANCE;
        end
      end
      S_DELIVER: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      gen_q       <= {B{1'b1}};
      cnt_q       <= '0;
      rr_q        <= '0;
      grant_idx_q <= '0;
      ack_q       <= '0;
      rand_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gen_q       <= gen_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      grant_idx_q <= grant_idx_d;
      ack_q       <= ack_d;
      rand_q      <= rand_d;
      busy_q      <= busy_d;
    end
  end

  assign ack       = ack_q;
  assign grant_idx = grant_idx_q;
  assign rand_data = rand_q;
  assign busy      = busy_q;

endmodule
